// File: rtl/sample_stream_harness.sv
// Feature-stream harness: assembles NUM_A feature words into a classifier input vector,
// captures the classifier result after CLS_LAT cycles, and keeps sample/class histograms.
module sample_stream_harness #(
   parameter int NUM_A    = 6,
   parameter int WIDTH_A  = 4,
   parameter int OUTWIDTH = 2,
   parameter int CLS_LAT  = 0,
   parameter int CNT_W    = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     feat_valid,
   input  logic [WIDTH_A-1:0]       feat_data,
   output logic                     feat_ready,
   output logic [NUM_A*WIDTH_A-1:0] inp,
   input  logic [OUTWIDTH-1:0]      cls_out,
   output logic                     res_valid,
   output logic [OUTWIDTH-1:0]      res_class,
   input  logic                     res_ready,
   output logic [CNT_W-1:0]         sample_cnt,
   input  logic [OUTWIDTH-1:0]      hist_sel,
   output logic [CNT_W-1:0]         hist_cnt,
   output logic                     busy
);

   localparam int               IDX_W    = (NUM_A > 1) ? $clog2(NUM_A) : 1;
   localparam int               BINS     = 2 ** OUTWIDTH;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_A - 1);
   localparam logic [3:0]       LAT      = 4'(CLS_LAT);

   typedef enum logic [1:0] {LOAD, WAIT, HOLD} state_t;

   state_t           state, state_nxt;
   logic [IDX_W-1:0] idx;
   logic [3:0]       wait_cnt;
   logic [CNT_W-1:0] hist [BINS];
   logic             accept, capture, consume;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= LOAD;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         LOAD:    if (feat_valid && idx == LAST_IDX) state_nxt = WAIT;
         WAIT:    if (wait_cnt == 4'd0)              state_nxt = HOLD;
         HOLD:    if (res_ready)                     state_nxt = LOAD;
         default:                                    state_nxt = LOAD;
      endcase
   end

   always_comb begin
      feat_ready = (state == LOAD);
      busy       = (state != LOAD) || (idx != '0);
      accept     = feat_ready && feat_valid;
      capture    = (state == WAIT) && (wait_cnt == 4'd0);
      consume    = (state == HOLD) && res_ready;
   end

   // Datapath: feature assembly, latency countdown, result capture and statistics
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx        <= '0;
         wait_cnt   <= 4'd0;
         inp        <= '0;
         res_valid  <= 1'b0;
         res_class  <= '0;
         sample_cnt <= '0;
         for (int b = 0; b < BINS; b++) hist[b] <= '0;
      end else begin
         if (accept) begin
            for (int k = 0; k < NUM_A; k++)
               if (idx == IDX_W'(k)) inp[k*WIDTH_A +: WIDTH_A] <= feat_data;
            if (idx == LAST_IDX) begin
               idx      <= '0;
               wait_cnt <= LAT;
            end else begin
               idx <= idx + 1'b1;
            end
         end
         if (state == WAIT && wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
         if (capture) begin
            res_class <= cls_out;
            res_valid <= 1'b1;
         end
         if (consume) begin
            res_valid       <= 1'b0;
            sample_cnt      <= sat_inc(sample_cnt);
            hist[res_class] <= sat_inc(hist[res_class]);
         end
      end
   end

   assign hist_cnt = hist[hist_sel];

endmodule
